// File: rtl/mem_wb_stage_if.sv
// MEM -> WB pipeline bus.
// master: the MEM stage / driver side. It drives instruction fields and
//         stall/flush controls, and observes the registered WB outputs.
// slave : mem_wb_stage. It consumes the MEM-side fields and drives the
//         registered writeback fields.
interface mem_wb_stage_if;
  // MEM-side inputs to the stage
  logic        io_in_valid;
  logic        io_stall;
  logic        io_flush;
  logic [31:0] io_pc;
  logic [31:0] io_alu_out;
  logic [31:0] io_mem_rdata;
  logic [2:0]  io_funct3;
  logic [1:0]  io_wb_sel;
  logic [4:0]  io_rd;
  logic        io_reg_wen;

  // Registered WB-side outputs
  logic        io_out_valid;
  logic [31:0] io_pc_out;
  logic [31:0] io_alu_out_out;
  logic [31:0] io_data_out;
  logic [1:0]  io_wb_sel_out;
  logic [4:0]  io_rd_out;
  logic        io_reg_wen_out;
  logic        io_misaligned;
  logic [31:0] io_retire_count;

  modport master (
    output io_in_valid, io_stall, io_flush, io_pc, io_alu_out, io_mem_rdata,
           io_funct3, io_wb_sel, io_rd, io_reg_wen,
    input  io_out_valid, io_pc_out, io_alu_out_out, io_data_out, io_wb_sel_out,
           io_rd_out, io_reg_wen_out, io_misaligned, io_retire_count
  );

  modport slave (
    input  io_in_valid, io_stall, io_flush, io_pc, io_alu_out, io_mem_rdata,
           io_funct3, io_wb_sel, io_rd, io_reg_wen,
    output io_out_valid, io_pc_out, io_alu_out_out, io_data_out, io_wb_sel_out,
           io_rd_out, io_reg_wen_out, io_misaligned, io_retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data formatting, misaligned-load
// detection, write-enable qualification and a retired-instruction counter.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - mem_wb_stage_if.slave (MEM-side fields in, registered WB fields out)
// Update priority on each edge: flush, then stall, then capture.
// All outputs come straight from registers.
module mem_wb_stage (
  input logic           clock,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] alu_q;
  logic [31:0] data_q,   data_d;
  logic [1:0]  wb_sel_q;
  logic [4:0]  rd_q;
  logic        wen_q,    wen_d;
  logic        mis_q,    mis_d;
  logic [31:0] retire_q, retire_d;

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    off      = bus.io_alu_out[1:0];
    byte_sel = bus.io_mem_rdata[7:0];
    case (off)
      2'd0:    byte_sel = bus.io_mem_rdata[7:0];
      2'd1:    byte_sel = bus.io_mem_rdata[15:8];
      2'd2:    byte_sel = bus.io_mem_rdata[23:16];
      default: byte_sel = bus.io_mem_rdata[31:24];
    endcase
    half_sel = off[1] ? bus.io_mem_rdata[31:16] : bus.io_mem_rdata[15:0];

    // Formatting ignores wb_sel; only misalignment detection depends on it.
    data_d = '0;
    case (bus.io_funct3)
      3'b000:  data_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  data_d = {{16{half_sel[15]}}, half_sel};
      3'b010:  data_d = bus.io_mem_rdata;
      3'b100:  data_d = {24'd0, byte_sel};
      3'b101:  data_d = {16'd0, half_sel};
      default: data_d = '0;
    endcase

    mis_d = (bus.io_wb_sel == 2'd2) && bus.io_in_valid &&
            ((((bus.io_funct3 == 3'b001) || (bus.io_funct3 == 3'b101)) && off[0]) ||
             ((bus.io_funct3 == 3'b010) && (off != 2'd0)));
    if (mis_d) begin
      data_d = '0;
    end

    wen_d    = bus.io_in_valid && bus.io_reg_wen && (bus.io_rd != 5'd0) && !mis_d;
    retire_d = retire_q + {31'd0, bus.io_in_valid};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      alu_q    <= '0;
      data_q   <= '0;
      wb_sel_q <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      mis_q    <= 1'b0;
      retire_q <= '0;
    end else if (bus.io_flush) begin
      // Flush only kills the side-effecting flags; data fields hold.
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!bus.io_stall) begin
      valid_q  <= bus.io_in_valid;
      pc_q     <= bus.io_pc;
      alu_q    <= bus.io_alu_out;
      data_q   <= data_d;
      wb_sel_q <= bus.io_wb_sel;
      rd_q     <= bus.io_rd;
      wen_q    <= wen_d;
      mis_q    <= mis_d;
      retire_q <= retire_d;
    end
  end

  assign bus.io_out_valid    = valid_q;
  assign bus.io_pc_out       = pc_q;
  assign bus.io_alu_out_out  = alu_q;
  assign bus.io_data_out     = data_q;
  assign bus.io_wb_sel_out   = wb_sel_q;
  assign bus.io_rd_out       = rd_q;
  assign bus.io_reg_wen_out  = wen_q;
  assign bus.io_misaligned   = mis_q;
  assign bus.io_retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load/stall/flush/reset
// scenarios plus randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  logic clock;
  logic reset;
  int   tot;
  int   bad;

  mem_wb_stage_if bus();

  mem_wb_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected architectural state of the stage
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_alu;
  logic [31:0] m_data;
  logic [1:0]  m_wb_sel;
  logic [4:0]  m_rd;
  logic        m_wen;
  logic        m_mis;
  logic [31:0] m_count;

  logic [137:0] act_v;
  logic [137:0] exp_v;
  assign act_v = {bus.io_out_valid, bus.io_pc_out, bus.io_alu_out_out, bus.io_data_out,
                  bus.io_wb_sel_out, bus.io_rd_out, bus.io_reg_wen_out, bus.io_misaligned,
                  bus.io_retire_count};
  assign exp_v = {m_valid, m_pc, m_alu, m_data, m_wb_sel, m_rd, m_wen, m_mis, m_count};

  // Load formatting from the rule table, using shifts and arithmetic.
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_alu = 0; m_data = 0; m_wb_sel = 0;
    m_rd = 0; m_wen = 0; m_mis = 0; m_count = 0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then settle to 1 time unit after the edge.
  task automatic tick();
    int  off;
    bit  mis;
    @(posedge clock);
    if (reset) begin
      if (bus.io_flush) begin
        m_valid = 0; m_wen = 0; m_mis = 0;
      end else if (!bus.io_stall) begin
        off = int'(bus.io_alu_out[1:0]);
        mis = (bus.io_wb_sel == 2) && bus.io_in_valid &&
              ((((bus.io_funct3 == 1) || (bus.io_funct3 == 5)) && (off % 2 == 1)) ||
               ((bus.io_funct3 == 2) && (off != 0)));
        m_valid  = bus.io_in_valid;
        m_pc     = bus.io_pc;
        m_alu    = bus.io_alu_out;
        m_wb_sel = bus.io_wb_sel;
        m_rd     = bus.io_rd;
        m_data   = mis ? 32'd0 : fmt(bus.io_funct3, bus.io_alu_out[1:0], bus.io_mem_rdata);
        m_mis    = mis;
        m_wen    = bus.io_in_valid && bus.io_reg_wen && (bus.io_rd != 0) && !mis;
        if (bus.io_in_valid) m_count = m_count + 1;
      end
    end
    #1;
  endtask

  task automatic set_in(input bit v, input bit st, input bit fl, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [2:0] f3, input logic [1:0] ws,
                        input logic [4:0] rd, input bit wen);
    bus.io_in_valid = v;   bus.io_stall = st;  bus.io_flush = fl;
    bus.io_pc = pc;        bus.io_alu_out = alu; bus.io_mem_rdata = rdata;
    bus.io_funct3 = f3;    bus.io_wb_sel = ws; bus.io_rd = rd;
    bus.io_reg_wen = wen;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1, 0, 0, 32'h40, 32'h44, 32'h1234_5678, 3'd2, 2'd1, 5'd3, 1);
    model_reset();
    #3;
    tot++;
    if (act_v !== '0) begin
      bad++; $display("FAIL reset_state got=%h want=0", act_v);
    end
    tick();
    tot++;
    if (act_v !== '0) begin
      bad++; $display("FAIL reset_hold_edge got=%h want=0", act_v);
    end
    #5 reset = 1'b1;  // release mid-low-phase, away from the edge
    #1;
    set_in(1, 0, 0, 32'h80, 32'h84, 32'h0, 3'd2, 2'd1, 5'd7, 1);
    tick();
    tot++;
    if (bus.io_pc_out !== 32'h80 || bus.io_retire_count !== 32'd1 || bus.io_out_valid !== 1'b1) begin
      bad++; $display("FAIL first_capture got pc=%h cnt=%0d v=%b want pc=80 cnt=1 v=1",
                      bus.io_pc_out, bus.io_retire_count, bus.io_out_valid);
    end
  endtask

  task automatic test_lb();
    set_in(1, 0, 0, 32'h200, 32'h1003, 32'h80FF_1234, 3'b000, 2'd2, 5'd5, 1);
    tick();
    tot++;
    if (bus.io_data_out !== 32'hFFFF_FF80 || bus.io_reg_wen_out !== 1'b1 ||
        bus.io_misaligned !== 1'b0) begin
      bad++; $display("FAIL lb got data=%h wen=%b mis=%b want data=ffffff80 wen=1 mis=0",
                      bus.io_data_out, bus.io_reg_wen_out, bus.io_misaligned);
    end
  endtask

  task automatic test_lhu();
    set_in(1, 0, 0, 32'h204, 32'h2002, 32'hBEEF_0011, 3'b101, 2'd2, 5'd6, 1);
    tick();
    tot++;
    if (bus.io_data_out !== 32'h0000_BEEF || bus.io_misaligned !== 1'b0 ||
        bus.io_reg_wen_out !== 1'b1) begin
      bad++; $display("FAIL lhu got data=%h mis=%b wen=%b want data=0000beef mis=0 wen=1",
                      bus.io_data_out, bus.io_misaligned, bus.io_reg_wen_out);
    end
    set_in(1, 0, 0, 32'h208, 32'h2001, 32'hBEEF_0011, 3'b101, 2'd2, 5'd6, 1);
    tick();
    tot++;
    if (bus.io_data_out !== 32'd0 || bus.io_misaligned !== 1'b1 || bus.io_reg_wen_out !== 1'b0) begin
      bad++; $display("FAIL lhu_misaligned got data=%h mis=%b wen=%b want data=0 mis=1 wen=0",
                      bus.io_data_out, bus.io_misaligned, bus.io_reg_wen_out);
    end
  endtask

  task automatic test_rd_zero();
    logic [31:0] want_cnt;
    want_cnt = m_count + 1;
    set_in(1, 0, 0, 32'h20C, 32'h55, 32'hDEAD_BEEF, 3'b010, 2'd1, 5'd0, 1);
    tick();
    tot++;
    if (bus.io_alu_out_out !== 32'h55 || bus.io_reg_wen_out !== 1'b0 ||
        bus.io_out_valid !== 1'b1 || bus.io_retire_count !== want_cnt) begin
      bad++; $display("FAIL rd_zero got alu=%h wen=%b v=%b cnt=%0d want alu=55 wen=0 v=1 cnt=%0d",
                      bus.io_alu_out_out, bus.io_reg_wen_out, bus.io_out_valid,
                      bus.io_retire_count, want_cnt);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] cnt0;
    set_in(1, 0, 0, 32'h100, 32'h10, 32'h0, 3'b010, 2'd1, 5'd9, 1);
    tick();
    cnt0 = m_count;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom), 5'($urandom), 1);
      tick();
      tot++;
      if (bus.io_pc_out !== 32'h100 || bus.io_retire_count !== cnt0 || act_v !== exp_v) begin
        bad++; $display("FAIL stall_hold[%0d] got pc=%h cnt=%0d want pc=100 cnt=%0d",
                        i, bus.io_pc_out, bus.io_retire_count, cnt0);
      end
    end
    set_in(1, 1, 1, 32'h300, 32'h30, 32'h0, 3'b010, 2'd1, 5'd9, 1);
    tick();
    tot++;
    if (bus.io_out_valid !== 1'b0 || bus.io_reg_wen_out !== 1'b0 ||
        bus.io_retire_count !== cnt0 || bus.io_pc_out !== 32'h100) begin
      bad++; $display("FAIL flush_stall got v=%b wen=%b cnt=%0d pc=%h want v=0 wen=0 cnt=%0d pc=100",
                      bus.io_out_valid, bus.io_reg_wen_out, bus.io_retire_count,
                      bus.io_pc_out, cnt0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
             $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom),
             (($urandom % 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
      tick();
      tot++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL random[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    set_in(0, 0, 0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd3, 5'd0, 0);
    dut.retire_q = 32'hFFFF_FFFF;
    m_count      = 32'hFFFF_FFFF;
    set_in(1, 0, 0, 32'h400, 32'h4, 32'h0, 3'd2, 2'd1, 5'd1, 1);
    tick();
    tot++;
    if (bus.io_retire_count !== 32'd0) begin
      bad++; $display("FAIL count_wrap got=%h want=0", bus.io_retire_count);
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 0, 32'h500, 32'h1000, 32'h8000_0000, 3'd2, 2'd2, 5'd4, 1);
    tick();
    tot++;
    if (act_v !== exp_v || bus.io_out_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_capture got=%h want=%h", act_v, exp_v);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    tot++;
    if (act_v !== '0) begin
      bad++; $display("FAIL async_reset got=%h want=0", act_v);
    end
    tick();
    tot++;
    if (act_v !== '0) begin
      bad++; $display("FAIL reset_drops_capture got=%h want=0", act_v);
    end
    #5 reset = 1'b1;
    #1;
    tick();
    tot++;
    if (act_v !== exp_v || bus.io_retire_count !== 32'd1) begin
      bad++; $display("FAIL post_reset_capture got=%h want=%h", act_v, exp_v);
    end
  endtask

  initial begin
    tot = 0;
    bad = 0;
    test_reset();
    test_lb();
    test_lhu();
    test_rd_zero();
    test_stall_flush();
    test_random();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 resets all state immediately, independent of clock.
REQ-004 io_in_valid  in  1  MEM-stage instruction valid.
REQ-005 io_stall  in  1  hold all stage registers this cycle.
REQ-006 io_flush  in  1  kill the instruction being captured.
REQ-007 io_pc  in  32  instruction PC.
REQ-008 io_alu_out  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-009 io_mem_rdata  in  32  raw aligned data-memory word, valid in the same cycle as io_in_valid.
REQ-010 io_funct3  in  3  load width/sign code.
REQ-011 io_wb_sel  in  2  0=PC+4, 1=ALU, 2=load data, 3=none.
REQ-012 io_rd  in  5  destination register index.
REQ-013 io_reg_wen  in  1  register-write request.
REQ-014 io_out_valid  out  1  registered valid to writeback.
REQ-015 io_pc_out, io_alu_out_out  out  32 each  registered PC and ALU result.
REQ-016 io_data_out  out  32  registered, formatted load data.
REQ-017 io_wb_sel_out  out  2  registered wb_sel.
REQ-018 io_rd_out  out  5  registered rd.
REQ-019 io_reg_wen_out  out  1  registered, qualified write enable.
REQ-020 io_misaligned  out  1  registered misaligned-load flag.
REQ-021 io_retire_count  out  32  count of instructions captured into the stage.

Function
REQ-022 All outputs SHALL be registered; no combinational input-to-output path.
REQ-023 Update priority each edge SHALL be: flush, then stall, then capture.
REQ-024 Flush: out_valid<=0, reg_wen_out<=0, misaligned<=0; other fields hold.
REQ-025 Stall without flush: every register holds, including retire_count.
REQ-026 Capture (neither flush nor stall): pc, alu_out, wb_sel, rd registered from inputs; out_valid<=in_valid.
REQ-027 Load formatting from mem_rdata, off=alu_out[1:0]:
  - 000 LB: sign-extended byte[off].
  - 001 LH: sign-extended half[off[1]].
  - 010 LW: full word.
  - 100 LBU: zero-extended byte[off].
  - 101 LHU: zero-extended half[off[1]].
  - 011/110/111: 0.
REQ-028 Misaligned SHALL equal wb_sel==2 and in_valid and ((funct3 in {001,101} and off[0]=1) or (funct3=010 and off!=0)).
REQ-029 When misaligned, captured data_out SHALL be 0.
REQ-030 reg_wen_out SHALL capture in_valid & reg_wen & (rd!=0) & !misaligned.
REQ-031 Formatting SHALL be applied regardless of wb_sel; only misalignment detection depends on wb_sel==2.
REQ-032 retire_count SHALL increment by 1 on each capture edge with in_valid=1, and wrap 0xFFFFFFFF->0.
REQ-033 Flush and stall together: flush wins; count does not increment.

Reset
REQ-034 While reset=0, all outputs, including retire_count, SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL clear all state asynchronously; a pending capture is lost.
REQ-036 First capture SHALL occur on the first rising edge with reset=1.

Verification
REQ-037 LB: alu_out=0x1003, rdata=0x80FF1234, funct3=000, wb_sel=2, rd=5, wen=1 -> next edge: data_out=0xFFFFFF80, reg_wen_out=1, misaligned=0.
REQ-038 LHU: alu_out=0x2002, rdata=0xBEEF0011, funct3=101 -> data_out=0x0000BEEF; same with alu_out=0x2001 -> misaligned=1, data_out=0, reg_wen_out=0.
REQ-039 rd=0 with wen=1, wb_sel=1, alu_out=0x55 -> alu_out_out=0x55, reg_wen_out=0, out_valid=1, count+1.
REQ-040 Capture pc=0x100, then stall 3 cycles with new inputs -> pc_out stays 0x100, count unchanged; flush+stall -> out_valid=0.
REQ-041 Preload count near wrap via 2^32 captures or forced state 0xFFFFFFFF -> one valid capture -> count=0.
REQ-042 Drop reset to 0 between edges after valid capture -> all outputs 0 before next edge.
